// File: rtl/hamming_rd_if.sv
// Bus bundle between the ECC FIFO/decoder, the read controller and the downstream consumer.
// Stream handshake: a beat transfers on a rising edge where o_valid && i_ready; while
// o_valid is high and i_ready is low, o_data/o_cerr/o_uerr/o_err_pos hold their values.
interface hamming_rd_if #(
  parameter int DW = 512,
  parameter int PW = 10
);
  logic          i_fifo_empty;
  logic          o_fifo_rreq;
  logic [DW-1:0] i_data;
  logic [PW-1:0] i_err_pos;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_cerr;
  logic          o_uerr;
  logic [PW-1:0] o_err_pos;

  modport master (
    input  i_fifo_empty, i_data, i_err_pos, i_ready,
    output o_fifo_rreq, o_valid, o_data, o_cerr, o_uerr, o_err_pos
  );

  modport slave (
    output i_fifo_empty, i_data, i_err_pos, i_ready,
    input  o_fifo_rreq, o_valid, o_data, o_cerr, o_uerr, o_err_pos
  );
endinterface

// File: rtl/hamming_rd_ctrl.sv
// Read-side controller behind the Hamming ECC FIFO: pops decoded words into a 2-entry
// buffer, streams them out, classifies decoder syndromes and keeps saturating error counters.
module hamming_rd_ctrl #(
  parameter int DW = 512,
  parameter int PW = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  hamming_rd_if.master  bus,
  input  logic          i_clr_cnt,
  output logic [CW-1:0] o_cerr_cnt,
  output logic [CW-1:0] o_uerr_cnt,
  output logic          o_uerr_sticky,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] pos;
    logic          cerr;
    logic          uerr;
  } entry_t;

  localparam int unsigned   POS_LIMIT = DW + PW;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  state_e        state_q, state_d;
  entry_t        head_q, head_d, skid_q, skid_d, in_e;
  logic [CW-1:0] cerr_cnt_q, cerr_cnt_d, uerr_cnt_q, uerr_cnt_d;
  logic          sticky_q, sticky_d;
  logic          rreq, valid, pop, drain;
  logic [31:0]   pos_ext;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (pop) state_d = S_ONE;
      S_ONE: begin
        if (pop && !drain)      state_d = S_TWO;
        else if (!pop && drain) state_d = S_EMPTY;
      end
      S_TWO:   if (drain) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM outputs; rreq deliberately ignores i_ready to keep ready off the pop path.
  always_comb begin
    rreq  = 1'b0;
    valid = 1'b0;
    if (!reset && !bus.i_fifo_empty && (state_q != S_TWO)) rreq = 1'b1;
    if (state_q != S_EMPTY) valid = 1'b1;
  end

  assign pop   = rreq;
  assign drain = valid && bus.i_ready;

  // Classify the head word's syndrome as it is captured.
  always_comb begin
    pos_ext     = 32'(bus.i_err_pos);
    in_e.data   = bus.i_data;
    in_e.pos    = bus.i_err_pos;
    in_e.cerr   = (pos_ext != 32'd0) && (pos_ext <= POS_LIMIT);
    in_e.uerr   = (pos_ext > POS_LIMIT);
  end

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    unique case (state_q)
      S_EMPTY: if (pop) head_d = in_e;
      S_ONE: begin
        if (pop && drain) head_d = in_e;
        else if (pop)     skid_d = in_e;
      end
      S_TWO:   if (drain) head_d = skid_q;
      default: ;
    endcase
  end

  // Clear first, then count the pop of the same cycle.
  always_comb begin
    cerr_cnt_d = i_clr_cnt ? '0 : cerr_cnt_q;
    uerr_cnt_d = i_clr_cnt ? '0 : uerr_cnt_q;
    sticky_d   = i_clr_cnt ? 1'b0 : sticky_q;
    if (pop && in_e.cerr && (cerr_cnt_d != CNT_MAX)) cerr_cnt_d = cerr_cnt_d + 1'b1;
    if (pop && in_e.uerr) begin
      sticky_d = 1'b1;
      if (uerr_cnt_d != CNT_MAX) uerr_cnt_d = uerr_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      cerr_cnt_q <= '0;
      uerr_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      cerr_cnt_q <= cerr_cnt_d;
      uerr_cnt_q <= uerr_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.o_fifo_rreq = rreq;
  assign bus.o_valid     = valid;
  assign bus.o_data      = head_q.data;
  assign bus.o_err_pos   = head_q.pos;
  assign bus.o_cerr      = head_q.cerr;
  assign bus.o_uerr      = head_q.uerr;
  assign o_cerr_cnt      = cerr_cnt_q;
  assign o_uerr_cnt      = uerr_cnt_q;
  assign o_uerr_sticky   = sticky_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_hamming_rd_ctrl.sv
// Bench for hamming_rd_ctrl: directed scenarios followed by random traffic, all
// compared against a queue-based model of the FIFO, the output buffer and the counters.
module tb_hamming_rd_ctrl;
  localparam int DW      = 512;
  localparam int PW      = 10;
  localparam int CW      = 3;
  localparam int LIMIT   = DW + PW;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] pos;
  } word_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic clr;
  logic [CW-1:0] cerr_cnt, uerr_cnt;
  logic sticky;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  hamming_rd_if #(.DW(DW), .PW(PW)) bus ();

  hamming_rd_ctrl #(.DW(DW), .PW(PW), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .i_clr_cnt     (clr),
    .o_cerr_cnt    (cerr_cnt),
    .o_uerr_cnt    (uerr_cnt),
    .o_uerr_sticky (sticky),
    .o_dbg_state   (dbg_state)
  );

  // model state
  word_t fifo_q[$];
  word_t exp_q[$];
  int    m_cerr, m_uerr;
  bit    m_sticky, m_zero;
  int    n_cmp, n_bad;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_cerr(input logic [PW-1:0] p);
    return (int'(p) != 0) && (int'(p) <= LIMIT);
  endfunction

  function automatic bit is_uerr(input logic [PW-1:0] p);
    return int'(p) > LIMIT;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [PW-1:0] rand_pos();
    int sel;
    int p;
    sel = $urandom_range(0, 9);
    case (sel)
      4: begin
        case ($urandom_range(0, 4))
          0: p = 1;
          1: p = LIMIT - 1;
          2: p = LIMIT;
          3: p = LIMIT + 1;
          default: p = (1 << PW) - 1;
        endcase
      end
      5, 6: p = $urandom_range(1, LIMIT);
      7:    p = $urandom_range(LIMIT + 1, (1 << PW) - 1);
      default: p = 0;
    endcase
    return PW'(p);
  endfunction

  // driver tasks
  task automatic push_word(input logic [PW-1:0] p);
    word_t w;
    w.data = rand_data();
    w.pos  = p;
    fifo_q.push_back(w);
  endtask

  task automatic drive_fifo();
    bus.i_fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) begin
      bus.i_data    = fifo_q[0].data;
      bus.i_err_pos = fifo_q[0].pos;
    end else begin
      bus.i_data    = '0;
      bus.i_err_pos = '0;
    end
  endtask

  task automatic check_outputs();
    check_eq("o_valid", bus.o_valid, DW'(exp_q.size() != 0));
    check_eq("occupancy", dbg_state, DW'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check_eq("o_data", bus.o_data, exp_q[0].data);
      check_eq("o_err_pos", bus.o_err_pos, exp_q[0].pos);
      check_eq("o_cerr", bus.o_cerr, DW'(is_cerr(exp_q[0].pos)));
      check_eq("o_uerr", bus.o_uerr, DW'(is_uerr(exp_q[0].pos)));
    end else if (m_zero) begin
      check_eq("o_data_rst", bus.o_data, '0);
      check_eq("o_err_pos_rst", bus.o_err_pos, '0);
      check_eq("o_cerr_rst", bus.o_cerr, '0);
      check_eq("o_uerr_rst", bus.o_uerr, '0);
    end
    check_eq("cerr_cnt", cerr_cnt, DW'(m_cerr));
    check_eq("uerr_cnt", uerr_cnt, DW'(m_uerr));
    check_eq("uerr_sticky", sticky, DW'(m_sticky));
  endtask

  // One clock: check state, drive inputs, check rreq, then advance the model.
  task automatic step(input bit rst, input bit rdy, input bit clr_i);
    bit    exp_rreq, exp_drain;
    word_t w;
    @(negedge clk);
    check_outputs();
    reset       = rst;
    bus.i_ready = rdy;
    clr         = clr_i;
    #1;
    exp_rreq  = !rst && (fifo_q.size() != 0) && (exp_q.size() < 2);
    exp_drain = (exp_q.size() != 0) && rdy;
    check_eq("o_fifo_rreq", bus.o_fifo_rreq, DW'(exp_rreq));
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_cerr   = 0;
      m_uerr   = 0;
      m_sticky = 1'b0;
      m_zero   = 1'b1;
    end else begin
      if (clr_i) begin
        m_cerr   = 0;
        m_uerr   = 0;
        m_sticky = 1'b0;
      end
      if (exp_drain) void'(exp_q.pop_front());
      if (exp_rreq) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
        if (is_cerr(w.pos) && m_cerr < CNT_MAX) m_cerr++;
        if (is_uerr(w.pos)) begin
          m_sticky = 1'b1;
          if (m_uerr < CNT_MAX) m_uerr++;
        end
        m_zero = 1'b0;
      end
    end
    drive_fifo();
  endtask

  initial begin
    int mode;
    bit rdy;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    clr   = 1'b0;
    bus.i_ready = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    m_cerr = 0; m_uerr = 0; m_sticky = 1'b0; m_zero = 1'b1;

    // reset held, FIFO holding one clean word: no pop during reset
    push_word('0);
    drive_fifo();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // classification boundaries
    push_word(PW'(0)); push_word(PW'(1)); push_word(PW'(LIMIT));
    push_word(PW'(LIMIT + 1)); push_word(PW'((1 << PW) - 1));
    drive_fifo();
    repeat (7) step(1'b0, 1'b1, 1'b0);

    // clean 8-word stream at full rate
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push_word('0);
    drive_fifo();
    repeat (10) step(1'b0, 1'b1, 1'b0);

    // backpressure with 4 queued words
    for (int i = 0; i < 4; i++) push_word(rand_pos());
    drive_fifo();
    repeat (6) step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // saturation, then clear coinciding with an uncorrectable pop
    for (int i = 0; i < CNT_MAX + 2; i++) push_word(PW'(1 + i));
    drive_fifo();
    repeat (CNT_MAX + 4) step(1'b0, 1'b1, 1'b0);
    push_word(PW'(600));
    drive_fifo();
    step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);

    // reset while full and stalled
    for (int i = 0; i < 3; i++) push_word(rand_pos());
    drive_fifo();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // random traffic
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) mode = $urandom_range(0, 2);
      if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) push_word(rand_pos());
        drive_fifo();
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = $urandom_range(0, 1) == 1;
        default: rdy = $urandom_range(0, 4) == 0;
      endcase
      step($urandom_range(0, 400) == 0, rdy, $urandom_range(0, 40) == 0);
    end

    fifo_q.delete();
    drive_fifo();
    repeat (6) step(1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
